bcd_tally_counter: RTL and testbench
====================================

// Module: bcd_tally_counter
// PURPOSE
//  Parametrised up/down tally counter, NUM_DIGITS BCD digits, each driving one 7-segment display.
//  - Sits behind Debounce_Filter instances on the board push-buttons.
//  - Adds edge-only stepping, selectable saturate/wrap mode, hold-to-auto-repeat,
//    and limit flags over the fixed two-hex-digit tally.
// PARAMETERS
//  NUM_DIGITS     2      BCD digits; count range 0 .. 10^NUM_DIGITS-1
//  WRAP_MODE      0      0 = saturate at limits, 1 = wrap max<->0
//  HOLD_CYCLES    12500000  cycles a button is held before auto-repeat starts (0 disables repeat)
//  REPEAT_CYCLES  2500000   cycles between auto-repeat steps (>=1)
//  SEG_ACTIVE_LOW 1      1 = segment outputs inverted (board LEDs are active-low)
// PORTS
//  i_Clk      in   1              system clock; every register is clocked on its rising edge
//  i_Rst      in   1              asynchronous reset, active-high
//  i_Inc      in   1              debounced level, increment request
//  i_Dec      in   1              debounced level, decrement request
//  i_Clr      in   1              debounced level, clear request
//  o_Count    out  4*NUM_DIGITS   BCD count; digit 0 (units) in [3:0]
//  o_Segments out  7*NUM_DIGITS   segments per digit; digit d in [7d+6:7d], bit order G..A (A = LSB)
//  o_At_Max   out  1              count == 10^NUM_DIGITS-1
//  o_At_Min   out  1              count == 0
//  o_Step     out  1              one-cycle pulse, count changed on the previous edge
// BEHAVIOUR
//  - Reset values (i_Rst high, asynchronous):
//    - o_Count = 0, o_At_Min = 1, o_At_Max = 0, o_Step = 0.
//    - o_Segments = glyph "0" on every digit, polarity per SEG_ACTIVE_LOW.
//    - Edge registers = 0, FSM = S_IDLE.
//  - Edge detection:
//    - Previous levels of i_Inc/i_Dec/i_Clr are registered.
//    - A step fires only on a 0->1 edge or on an auto-repeat tick, never on a steady level.
//  - Latency:
//    - An edge sampled at edge k updates o_Count and the flags at edge k.
//    - o_Step is high for exactly one cycle after edge k.
//    - o_Segments is a combinational decode of o_Count, so it adds no further latency.
//  - Priority:
//    - Clr > (Inc xor Dec).
//    - A Clr edge sets the count to 0 and the FSM to S_IDLE.
//    - Inc and Dec high in the same cycle: no step and FSM to S_IDLE.
//    - Applies whether or not both inputs rose together.
//  - Arithmetic:
//    - Per-digit BCD with a ripple carry/borrow chain; digit 9+1 -> 0 with carry, 0-1 -> 9 with borrow.
//    - Never produces a non-BCD digit.
//  - Limits, WRAP_MODE = 0:
//    - Inc at max and Dec at 0 are ignored.
//    - No o_Step pulse and no count change.
//  - Limits, WRAP_MODE = 1:
//    - max+1 -> 0 and 0-1 -> max.
//    - o_Step pulses.
//  - Clr while the count is already 0: o_Step does not pulse.
//  - Auto-repeat FSM: S_IDLE, S_HOLD, S_REPEAT; a direction register holds Inc or Dec; a timer counts cycles.
//    - S_IDLE -> S_HOLD: on a single-direction edge. Step once, timer = 0.
//    - S_HOLD: timer increments.
//      - Timer reaches HOLD_CYCLES-1 -> S_REPEAT, step once, timer = 0.
//    - S_REPEAT: timer increments.
//      - Timer reaches REPEAT_CYCLES-1 -> step once, timer = 0.
//    - Any state -> S_IDLE when the held input drops, the opposite input rises, or Clr rises.
//    - HOLD_CYCLES = 0: S_HOLD is never left except to S_IDLE.
//  - Saturate mode with the hold continuing at a limit: FSM keeps running, steps are suppressed, no wrap.
//  - Timer width: $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)+1).
//  - Reset mid-hold: everything returns to its reset value immediately (asynchronous).
//    - After i_Rst falls, a still-high button does not step until it is released and pressed again,
//      because the edge register resets to 0 and is then re-armed by a 0 level.
// STRUCTURE
//  - Include file tally_defs.vh:
//    - FSM state encodings S_IDLE/S_HOLD/S_REPEAT.
//    - 7-segment glyph constants for 0-9.
//  - Sub-module tally_bcd_digit, one per digit via generate:
//    - Ports: i_Clk, i_Rst, i_Inc_En, i_Dec_En, i_Clr, o_Digit[3:0], o_Carry, o_Borrow.
//    - The top level chains o_Carry/o_Borrow into the next digit's enables.
//    - The top level also decides limit suppression before enabling digit 0.
//  - Segment decode is a combinational case on each digit in the top level, using the tally_defs.vh glyphs.
// TESTING
//  Bench uses NUM_DIGITS=2, HOLD_CYCLES=8, REPEAT_CYCLES=3 unless stated.
//  1. Reset, then 3 single-cycle Inc pulses.
//     -> o_Count=8'h03; three o_Step pulses.
//     -> Digit-0 segments = glyph "3", inverted.
//  2. Inc held 20 cycles from edge.
//     -> Steps at cycle 0, then 8, 11, 14, 17.
//     -> o_Count=8'h05; o_Step count 5.
//  3. WRAP_MODE=0: count 8'h99, Inc edge.
//     -> Stays 8'h99, no o_Step, o_At_Max=1.
//  4. WRAP_MODE=0: count 8'h00, Dec edge.
//     -> Stays 8'h00, no o_Step, o_At_Min=1.
//  5. WRAP_MODE=1: count 8'h99, Inc edge.
//     -> 8'h00 with o_Step.
//  6. WRAP_MODE=1: count 8'h00, Dec edge.
//     -> 8'h99 with o_Step.
//  7. Count 8'h19, Inc edge.
//     -> 8'h20 (carry).
//  8. Count 8'h20, Dec edge.
//     -> 8'h19 (borrow).
//  9. Inc and Dec rise together.
//     -> No change.
//  10. Clr edge while Inc is held in S_REPEAT.
//     -> 8'h00, FSM S_IDLE.
//     -> No further steps until Inc is re-pressed.
//  11. i_Rst pulsed asynchronously, mid-cycle, during S_HOLD at count 8'h42.
//     -> Outputs reach reset values before the next clock edge.
//     -> A held Inc does not step after reset is released.

Source files
------------

// File: rtl/bcd_tally_counter_pkg.sv
// Shared definitions for the BCD tally counter: auto-repeat FSM states and
// 7-segment glyphs (bit order G..A, A = LSB, active-high form).
package bcd_tally_counter_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HOLD   = 2'd1,
      S_REPEAT = 2'd2
   } tally_state_e;

   localparam logic [6:0] GLYPH_0 = 7'h3F;
   localparam logic [6:0] GLYPH_1 = 7'h06;
   localparam logic [6:0] GLYPH_2 = 7'h5B;
   localparam logic [6:0] GLYPH_3 = 7'h4F;
   localparam logic [6:0] GLYPH_4 = 7'h66;
   localparam logic [6:0] GLYPH_5 = 7'h6D;
   localparam logic [6:0] GLYPH_6 = 7'h7D;
   localparam logic [6:0] GLYPH_7 = 7'h07;
   localparam logic [6:0] GLYPH_8 = 7'h7F;
   localparam logic [6:0] GLYPH_9 = 7'h6F;
   localparam logic [6:0] GLYPH_BLANK = 7'h00;

endpackage

// File: rtl/bcd_tally_counter_digit.sv
// One BCD digit of the tally: clear, increment or decrement by one, with
// carry/borrow out when the step rolls the digit over.
module tally_bcd_digit (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_Inc_En,
   input  logic       i_Dec_En,
   input  logic       i_Clr,
   output logic [3:0] o_Digit,
   output logic       o_Carry,
   output logic       o_Borrow
);

   logic [3:0] digit_q;
   logic [3:0] digit_d;

   // Next digit value; anything out of range is pulled back into 0..9
   always_comb begin
      digit_d = digit_q;
      if (i_Clr) begin
         digit_d = 4'd0;
      end else if (i_Inc_En) begin
         digit_d = (digit_q >= 4'd9) ? 4'd0 : digit_q + 4'd1;
      end else if (i_Dec_En) begin
         digit_d = ((digit_q == 4'd0) || (digit_q > 4'd9)) ? 4'd9 : digit_q - 4'd1;
      end else begin
         digit_d = digit_q;
      end
   end

   // Digit register
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         digit_q <= 4'd0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign o_Digit  = digit_q;
   assign o_Carry  = i_Inc_En & (digit_q >= 4'd9);
   assign o_Borrow = i_Dec_En & (digit_q == 4'd0);

endmodule

// File: rtl/bcd_tally_counter.sv
// Up/down BCD tally counter with edge-only stepping, hold-to-auto-repeat,
// saturate or wrap at the limits, limit flags and 7-segment decode.
module bcd_tally_counter
   import bcd_tally_counter_pkg::*;
#(
   parameter int NUM_DIGITS     = 2,
   parameter int WRAP_MODE      = 0,
   parameter int HOLD_CYCLES    = 12500000,
   parameter int REPEAT_CYCLES  = 2500000,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                    i_Clk,
   input  logic                    i_Rst,
   input  logic                    i_Inc,
   input  logic                    i_Dec,
   input  logic                    i_Clr,
   output logic [4*NUM_DIGITS-1:0] o_Count,
   output logic [7*NUM_DIGITS-1:0] o_Segments,
   output logic                    o_At_Max,
   output logic                    o_At_Min,
   output logic                    o_Step
);

   localparam int TIMER_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
   localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
   localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
   localparam logic [TIMER_W-1:0] REP_LAST  = TIMER_W'(REPEAT_CYCLES - 1);
   localparam bit REPEAT_EN = (HOLD_CYCLES != 0);
   localparam bit WRAP_EN   = (WRAP_MODE != 0);
   localparam logic [4*NUM_DIGITS-1:0] MAX_BCD    = {NUM_DIGITS{4'd9}};
   localparam logic [4*NUM_DIGITS-1:0] MAX_M1_BCD = MAX_BCD - (4*NUM_DIGITS)'(1);
   localparam logic [4*NUM_DIGITS-1:0] ONE_BCD    = (4*NUM_DIGITS)'(1);

   tally_state_e         state_q, state_d;
   logic                 dir_up_q, dir_up_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 inc_arm_q, dec_arm_q, clr_arm_q;
   logic                 step_q, step_d;
   logic                 at_max_q, at_max_d;
   logic                 at_min_q, at_min_d;

   logic                 inc_rise_s, dec_rise_s, clr_rise_s, held_s;
   logic                 fire_s, clr_fire_s, inc_en0_s, dec_en0_s;
   logic [NUM_DIGITS:0]  inc_chain_s, dec_chain_s;
   logic [4*NUM_DIGITS-1:0] count_s;
   logic [7*NUM_DIGITS-1:0] seg_s;
   logic [6:0]           glyph_s;

   // Arm registers reset to 0 and only re-arm on a low level, so a button
   // still held through reset must be released before it can step again.
   assign inc_rise_s = i_Inc & inc_arm_q;
   assign dec_rise_s = i_Dec & dec_arm_q;
   assign clr_rise_s = i_Clr & clr_arm_q;
   assign held_s     = dir_up_q ? i_Inc : i_Dec;

   // Auto-repeat next state and step request
   always_comb begin
      state_d    = state_q;
      dir_up_d   = dir_up_q;
      timer_d    = timer_q;
      fire_s     = 1'b0;
      clr_fire_s = 1'b0;
      if (clr_rise_s) begin
         clr_fire_s = 1'b1;
         state_d    = S_IDLE;
         timer_d    = '0;
      end else if (i_Inc & i_Dec) begin
         state_d = S_IDLE;
         timer_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (inc_rise_s | dec_rise_s) begin
                  state_d  = S_HOLD;
                  dir_up_d = inc_rise_s;
                  timer_d  = '0;
                  fire_s   = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_HOLD: begin
               if (!held_s) begin
                  state_d = S_IDLE;
                  timer_d = '0;
               end else if (REPEAT_EN && (timer_q == HOLD_LAST)) begin
                  state_d = S_REPEAT;
                  timer_d = '0;
                  fire_s  = 1'b1;
               end else if (REPEAT_EN) begin
                  timer_d = timer_q + TIMER_ONE;
               end else begin
                  timer_d = timer_q;
               end
            end
            S_REPEAT: begin
               if (!held_s) begin
                  state_d = S_IDLE;
                  timer_d = '0;
               end else if (timer_q == REP_LAST) begin
                  timer_d = '0;
                  fire_s  = 1'b1;
               end else begin
                  timer_d = timer_q + TIMER_ONE;
               end
            end
            default: begin
               state_d = S_IDLE;
               timer_d = '0;
            end
         endcase
      end
   end

   // Saturate mode drops steps that would cross a limit; wrap mode lets the
   // digit chain roll over on its own.
   assign inc_en0_s = fire_s & dir_up_d & (WRAP_EN | ~at_max_q);
   assign dec_en0_s = fire_s & ~dir_up_d & (WRAP_EN | ~at_min_q);
   assign step_d    = inc_en0_s | dec_en0_s | (clr_fire_s & ~at_min_q);

   assign inc_chain_s[0] = inc_en0_s;
   assign dec_chain_s[0] = dec_en0_s;

   genvar gd;
   generate
      for (gd = 0; gd < NUM_DIGITS; gd++) begin : g_digit
         tally_bcd_digit u_digit (
            .i_Clk    (i_Clk),
            .i_Rst    (i_Rst),
            .i_Inc_En (inc_chain_s[gd]),
            .i_Dec_En (dec_chain_s[gd]),
            .i_Clr    (clr_fire_s),
            .o_Digit  (count_s[4*gd +: 4]),
            .o_Carry  (inc_chain_s[gd+1]),
            .o_Borrow (dec_chain_s[gd+1])
         );
      end
   endgenerate

   // Flags for the value the digits take on this edge; a carry/borrow out of
   // the top digit is a full rollover.
   always_comb begin
      at_max_d = ~clr_fire_s & (dec_chain_s[NUM_DIGITS]
                 | (inc_en0_s & (count_s == MAX_M1_BCD))
                 | (at_max_q & ~inc_en0_s & ~dec_en0_s));
      at_min_d = clr_fire_s | inc_chain_s[NUM_DIGITS]
                 | (dec_en0_s & (count_s == ONE_BCD))
                 | (at_min_q & ~inc_en0_s & ~dec_en0_s);
   end

   // Control registers: FSM, edge arms, step pulse and limit flags
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q   <= S_IDLE;
         dir_up_q  <= 1'b0;
         timer_q   <= '0;
         inc_arm_q <= 1'b0;
         dec_arm_q <= 1'b0;
         clr_arm_q <= 1'b0;
         step_q    <= 1'b0;
         at_max_q  <= 1'b0;
         at_min_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         dir_up_q  <= dir_up_d;
         timer_q   <= timer_d;
         inc_arm_q <= ~i_Inc;
         dec_arm_q <= ~i_Dec;
         clr_arm_q <= ~i_Clr;
         step_q    <= step_d;
         at_max_q  <= at_max_d;
         at_min_q  <= at_min_d;
      end
   end

   // Per-digit 7-segment decode of the registered count
   always_comb begin
      seg_s   = '0;
      glyph_s = GLYPH_BLANK;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         case (count_s[4*d +: 4])
            4'd0:    glyph_s = GLYPH_0;
            4'd1:    glyph_s = GLYPH_1;
            4'd2:    glyph_s = GLYPH_2;
            4'd3:    glyph_s = GLYPH_3;
            4'd4:    glyph_s = GLYPH_4;
            4'd5:    glyph_s = GLYPH_5;
            4'd6:    glyph_s = GLYPH_6;
            4'd7:    glyph_s = GLYPH_7;
            4'd8:    glyph_s = GLYPH_8;
            4'd9:    glyph_s = GLYPH_9;
            default: glyph_s = GLYPH_BLANK;
         endcase
         seg_s[7*d +: 7] = (SEG_ACTIVE_LOW != 0) ? ~glyph_s : glyph_s;
      end
   end

   assign o_Count    = count_s;
   assign o_Segments = seg_s;
   assign o_At_Max   = at_max_q;
   assign o_At_Min   = at_min_q;
   assign o_Step     = step_q;

endmodule

// File: tb/tb_bcd_tally_counter.sv
// Bench for bcd_tally_counter: a saturating and a wrapping instance share the
// same stimulus and are compared every cycle against a cycle-age model.
module tb_bcd_tally_counter;

   localparam int HOLD = 8;
   localparam int REP  = 3;
   localparam int MAXV = 99;

   typedef struct {
      logic       inc;
      logic       dec;
      logic       clr;
      logic [7:0] c0;
      logic       s0;
      logic [7:0] c1;
      logic       s1;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inc = 1'b0;
   logic        dec = 1'b0;
   logic        clr = 1'b0;
   logic [7:0]  cnt0, cnt1;
   logic [13:0] seg0, seg1;
   logic        mx0, mx1, mn0, mn1, st0, st1;

   int n_vec = 0;
   int n_err = 0;

   // model state: held age in cycles since the press edge (-1 = not holding)
   int  m_cnt [2];
   bit  m_step [2];
   int  m_age;
   bit  m_dir_up;
   bit  arm_i, arm_d, arm_c;
   logic [6:0] gl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   always #5 clk = ~clk;

   bcd_tally_counter #(.NUM_DIGITS(2), .WRAP_MODE(0), .HOLD_CYCLES(HOLD),
                       .REPEAT_CYCLES(REP), .SEG_ACTIVE_LOW(1)) dut0 (
      .i_Clk(clk), .i_Rst(rst), .i_Inc(inc), .i_Dec(dec), .i_Clr(clr),
      .o_Count(cnt0), .o_Segments(seg0), .o_At_Max(mx0), .o_At_Min(mn0), .o_Step(st0));

   bcd_tally_counter #(.NUM_DIGITS(2), .WRAP_MODE(1), .HOLD_CYCLES(HOLD),
                       .REPEAT_CYCLES(REP), .SEG_ACTIVE_LOW(1)) dut1 (
      .i_Clk(clk), .i_Rst(rst), .i_Inc(inc), .i_Dec(dec), .i_Clr(clr),
      .o_Count(cnt1), .o_Segments(seg1), .o_At_Max(mx1), .o_At_Min(mn1), .o_Step(st1));

   task automatic cmp(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   function automatic logic [13:0] segs_of(input int v);
      logic [13:0] r;
      r[13:7] = ~gl[v / 10];
      r[6:0]  = ~gl[v % 10];
      return r;
   endfunction

   task automatic model_reset();
      m_cnt  = '{0, 0};
      m_step = '{1'b0, 1'b0};
      m_age  = -1;
      m_dir_up = 1'b0;
      arm_i = 1'b0; arm_d = 1'b0; arm_c = 1'b0;
   endtask

   // k = 0 saturates, k = 1 wraps
   task automatic bump(input bit up);
      for (int k = 0; k < 2; k++) begin
         if (up) begin
            if (m_cnt[k] < MAXV) begin m_cnt[k]++; m_step[k] = 1'b1; end
            else if (k == 1) begin m_cnt[k] = 0; m_step[k] = 1'b1; end
         end else begin
            if (m_cnt[k] > 0) begin m_cnt[k]--; m_step[k] = 1'b1; end
            else if (k == 1) begin m_cnt[k] = MAXV; m_step[k] = 1'b1; end
         end
      end
   endtask

   task automatic model_step();
      bit ie, de, ce;
      ie = inc & arm_i; de = dec & arm_d; ce = clr & arm_c;
      arm_i = !inc; arm_d = !dec; arm_c = !clr;
      m_step = '{1'b0, 1'b0};
      if (ce) begin
         for (int k = 0; k < 2; k++) begin
            m_step[k] = (m_cnt[k] != 0);
            m_cnt[k]  = 0;
         end
         m_age = -1;
      end else if (inc && dec) begin
         m_age = -1;
      end else if (m_age < 0) begin
         if (ie || de) begin
            m_dir_up = ie;
            m_age = 0;
            bump(m_dir_up);
         end
      end else if (!(m_dir_up ? inc : dec)) begin
         m_age = -1;
      end else begin
         m_age++;
         if (m_age >= HOLD && ((m_age - HOLD) % REP) == 0) bump(m_dir_up);
      end
   endtask

   task automatic check_model();
      cmp("cnt0", cnt0, to_bcd(m_cnt[0]));
      cmp("seg0", seg0, segs_of(m_cnt[0]));
      cmp("max0", mx0, m_cnt[0] == MAXV);
      cmp("min0", mn0, m_cnt[0] == 0);
      cmp("step0", st0, m_step[0]);
      cmp("cnt1", cnt1, to_bcd(m_cnt[1]));
      cmp("seg1", seg1, segs_of(m_cnt[1]));
      cmp("max1", mx1, m_cnt[1] == MAXV);
      cmp("min1", mn1, m_cnt[1] == 0);
      cmp("step1", st1, m_step[1]);
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
      check_model();
   endtask

   task automatic press(input int n_inc);
      for (int i = 0; i < n_inc; i++) begin
         inc = 1'b1; tick();
         inc = 1'b0; tick();
      end
   endtask

   vec_t tbl [19];
   int   nsteps;

   initial begin
      tbl = '{
         '{1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 8'h01, 1'b1},
         '{1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 8'h01, 1'b0},
         '{1'b1, 1'b0, 1'b0, 8'h02, 1'b1, 8'h02, 1'b1},
         '{1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 8'h02, 1'b0},
         '{1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 8'h03, 1'b1},
         '{1'b0, 1'b0, 1'b0, 8'h03, 1'b0, 8'h03, 1'b0},
         '{1'b0, 1'b1, 1'b0, 8'h02, 1'b1, 8'h02, 1'b1},
         '{1'b1, 1'b1, 1'b0, 8'h02, 1'b0, 8'h02, 1'b0},
         '{1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 8'h02, 1'b0},
         '{1'b1, 1'b1, 1'b0, 8'h02, 1'b0, 8'h02, 1'b0},
         '{1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 8'h02, 1'b0},
         '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1},
         '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0},
         '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0},
         '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0},
         '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h99, 1'b1},
         '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h99, 1'b0},
         '{1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 8'h00, 1'b1},
         '{1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 8'h00, 1'b0}
      };

      model_reset();
      tick();
      tick();
      cmp("rst_cnt", cnt0, 8'h00);
      cmp("rst_seg", seg0, 14'h2040);
      cmp("rst_min", mn0, 1'b1);
      cmp("rst_max", mx0, 1'b0);
      cmp("rst_step", st0, 1'b0);
      rst = 1'b0;
      tick();

      // directed table: pulses, both-pressed, clear, limits in both modes
      for (int i = 0; i < 19; i++) begin
         inc = tbl[i].inc; dec = tbl[i].dec; clr = tbl[i].clr;
         tick();
         cmp($sformatf("tbl%0d_c0", i), cnt0, tbl[i].c0);
         cmp($sformatf("tbl%0d_s0", i), st0, tbl[i].s0);
         cmp($sformatf("tbl%0d_c1", i), cnt1, tbl[i].c1);
         cmp($sformatf("tbl%0d_s1", i), st1, tbl[i].s1);
         if (i == 5) cmp("glyph3", seg0[6:0], 7'h30);
         if (i == 15) cmp("sat_min", mn0, 1'b1);
      end

      // hold Inc for 20 cycles: steps at 0, 8, 11, 14, 17
      clr = 1'b1; tick(); clr = 1'b0; tick();
      nsteps = 0;
      inc = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (st0) nsteps++;
      end
      inc = 1'b0; tick();
      cmp("hold_steps", nsteps, 5);
      cmp("hold_cnt", cnt0, 8'h05);

      // carry 19 -> 20 and borrow 20 -> 19
      clr = 1'b1; tick(); clr = 1'b0; tick();
      press(19);
      cmp("pre_carry", cnt0, 8'h19);
      inc = 1'b1; tick(); cmp("carry", cnt0, 8'h20);
      inc = 1'b0; tick();
      dec = 1'b1; tick(); cmp("borrow", cnt0, 8'h19);
      dec = 1'b0; tick();

      // saturate at 99 while holding, then a fresh edge at max
      inc = 1'b1;
      repeat (300) tick();
      inc = 1'b0; tick();
      cmp("sat_cnt", cnt0, 8'h99);
      cmp("sat_max", mx0, 1'b1);
      inc = 1'b1; tick();
      cmp("sat_edge_cnt", cnt0, 8'h99);
      cmp("sat_edge_step", st0, 1'b0);
      inc = 1'b0; tick();

      // clear while repeating, then no steps until re-pressed
      clr = 1'b1; tick(); clr = 1'b0; tick();
      inc = 1'b1;
      repeat (13) tick();
      clr = 1'b1; tick();
      cmp("clr_rep_cnt", cnt0, 8'h00);
      clr = 1'b0;
      nsteps = 0;
      repeat (15) begin
         tick();
         if (st0) nsteps++;
      end
      cmp("clr_rep_steps", nsteps, 0);
      cmp("clr_rep_hold", cnt0, 8'h00);
      inc = 1'b0; tick();
      inc = 1'b1; tick();
      cmp("clr_repress", cnt0, 8'h01);
      inc = 1'b0; tick();

      // asynchronous reset mid-hold at 42
      clr = 1'b1; tick(); clr = 1'b0; tick();
      press(41);
      inc = 1'b1;
      repeat (4) tick();
      cmp("pre_rst_cnt", cnt0, 8'h42);
      rst = 1'b1;
      #1;
      model_reset();
      cmp("arst_cnt", cnt0, 8'h00);
      cmp("arst_seg", seg0, 14'h2040);
      cmp("arst_min", mn0, 1'b1);
      cmp("arst_max", mx0, 1'b0);
      cmp("arst_step", st0, 1'b0);
      cmp("arst_cnt1", cnt1, 8'h00);
      #1;
      rst = 1'b0;
      repeat (15) tick();
      cmp("post_rst_held", cnt0, 8'h00);
      inc = 1'b0; tick();
      inc = 1'b1; tick();
      cmp("post_rst_repress", cnt0, 8'h01);

      // randomized holds, releases, overlaps and clears
      for (int i = 0; i < 800; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 6) inc = ~inc;
         else if (r < 10) dec = ~dec;
         clr = (r >= 97);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
